iic_reg_ctrl: RTL and testbench
===============================

Name: iic_reg_ctrl

Overview:
Command sequencer sitting directly upstream of the IIC byte master. Accepts register-level read/write commands from the system side. Drives the master's start/continue pulses and transmit byte, and consumes its w_done/drdy/trans_done/trans_err events. Turns one command into a full device-address, register-address, data-burst transaction, including the repeated start for reads.

Parameters:
TO_W, 18, width of the event watchdog counter (optional feature only)
TIMEOUT_CYC, 200000, clk cycles allowed between master events before abort (optional feature only)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE; command accepted when cmd_valid&cmd_ready
cmd_rw  in  1  1=read, 0=write
cmd_dev  in  7  7-bit device address
cmd_reg  in  8  register address
cmd_len  in  4  data bytes, 1..15; 0 is treated as 1
wdata  in  8  current write byte; must be valid from acceptance until its wd_ack
wd_ack  out  1  1-cycle pulse; current wdata byte consumed, next byte to be presented
rdata  out  8  received byte, valid with rd_valid
rd_valid  out  1  1-cycle pulse per received byte
busy  out  1  high from command accept until done
done  out  1  1-cycle pulse at end of transaction
err  out  1  status of last transaction; valid with done, held until next accept
iic_start  out  1  1-cycle start/restart request to master
iic_continue  out  1  1-cycle continue request to master
iic_tx_data  out  8  byte presented to master
iic_rx_data  in  8  byte received by master
iic_w_done  in  1  master finished sending a byte
iic_drdy  in  1  master finished receiving a byte
iic_trans_done  in  1  master completed STOP
iic_trans_err  in  1  master saw missing slave ACK

Behaviour:
- Reset values: cmd_ready=1 (IDLE), busy=0, done=0, err=0, wd_ack=0, rd_valid=0, rdata=0, iic_start=0, iic_continue=0, iic_tx_data=8'h00. All registers are reset asynchronously by rstn. Reset mid-transaction returns to IDLE immediately; master is reset by the same rstn.
- Internal latches at accept: rw, dev, reg, remaining-byte counter rem = (cmd_len==0 ? 1 : cmd_len). err is cleared.
- States and transitions:
  - IDLE -> ADDR_W on accept. Same cycle registers iic_tx_data={dev,1'b0}. iic_start pulses in the cycle after accept.
  - ADDR_W: on iic_w_done -> REG. Next cycle: iic_tx_data=reg, iic_continue pulse.
  - REG: on iic_w_done. If write -> WDATA, with iic_tx_data=wdata and iic_continue pulse next cycle. If read -> ADDR_R, with iic_tx_data={dev,1'b1} and iic_start pulse next cycle (repeated start, no continue).
  - WDATA: on iic_w_done, wd_ack pulses and rem decrements.
    - rem>1 after decrement: iic_tx_data=wdata (next byte, sampled 1 cycle after wd_ack), iic_continue pulse.
    - otherwise: no pulse -> WAIT_STOP.
  - ADDR_R: on iic_w_done -> RDATA. If rem>1, iic_continue pulses (master ACKs the coming byte).
  - RDATA: on iic_drdy, rdata=iic_rx_data and rd_valid pulses 1 cycle later; rem decrements.
    - rem>1 after decrement: iic_continue pulse (ACK).
    - else: no pulse (NACK) -> WAIT_STOP.
  - WAIT_STOP: on iic_trans_done -> DONE.
  - DONE: done pulses 1 cycle -> IDLE.
- Event-to-pulse latency: iic_start/iic_continue are asserted exactly 1 clk after the triggering event. iic_tx_data is updated in the same cycle as or before the pulse, and is held stable until the next byte event.
- iic_trans_err in any busy state: err<=1, all further pulses suppressed, -> WAIT_STOP. If iic_trans_done arrives in the same cycle, go directly to DONE.
- iic_trans_done in any state other than WAIT_STOP while busy (premature stop): err<=1 -> DONE.
- Master events while IDLE are ignored. cmd_valid while busy is ignored (cmd_ready=0).
- Simultaneous iic_w_done and iic_drdy: only the one expected by the current state is acted on; the other is ignored.
- rem is 4 bits, never underflows; decrements only while rem>=1.

Optional Feature:
IIC_CTRL_TIMEOUT_EN
- Defined: a TO_W-bit counter clears on accept and on every master event (w_done, drdy, trans_done, trans_err), and increments while busy. On reaching TIMEOUT_CYC: err<=1, done pulses, FSM -> IDLE without waiting for a stop. Master state is the integrator's responsibility.
- Not defined: no counter is built; WAIT_STOP and the byte states wait indefinitely.

Test Plan:
1. Write dev=7'h50, reg=8'h10, len=1, wdata=8'hA5, slave always ACKs -> iic_tx_data sequence 8'hA0, 8'h10, 8'hA5. Two continue pulses, one start, one wd_ack, done with err=0.
2. Read dev=7'h50, reg=8'h02, len=3, slave returns 8'h11, 8'h22, 8'h33 -> two starts (2nd with tx 8'hA1), continue after 8'hA1 and after first two drdy only. rd_valid x3 with those values, done err=0.
3. Write with slave NACK on address (iic_trans_err after first byte) -> no further iic_continue, no wd_ack. Done after iic_trans_done with err=1.
4. cmd_len=0 write, wdata=8'h3C -> behaves as len=1: exactly one wd_ack, done err=0.
5. Assert rstn low during RDATA of a len=4 read -> all outputs return to reset values next edge; a new command after release completes normally.
6. With IIC_CTRL_TIMEOUT_EN, TIMEOUT_CYC=1000, master stalls after iic_start -> done with err=1 exactly 1000 cycles after the last event; cmd_ready=1 the following cycle.

Source files
------------

// File: rtl/iic_reg_ctrl.sv
// Register-level command sequencer driving the IIC byte master (addr/reg/data bursts, restart on reads).
// Optional event watchdog: define IIC_CTRL_TIMEOUT_EN.

module iic_reg_ctrl
`ifdef IIC_CTRL_TIMEOUT_EN
#(
    parameter int unsigned TO_W        = 18,
    parameter int unsigned TIMEOUT_CYC = 200000
)
`endif
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_dev,
    input  logic [7:0] cmd_reg,
    input  logic [3:0] cmd_len,
    input  logic [7:0] wdata,
    output logic       wd_ack,
    output logic [7:0] rdata,
    output logic       rd_valid,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       iic_start,
    output logic       iic_continue,
    output logic [7:0] iic_tx_data,
    input  logic [7:0] iic_rx_data,
    input  logic       iic_w_done,
    input  logic       iic_drdy,
    input  logic       iic_trans_done,
    input  logic       iic_trans_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_W, S_REG, S_WDATA, S_WNEXT,
        S_ADDR_R, S_RDATA, S_WAIT_STOP, S_DONE
    } state_e;

    state_e     state_q, state_d;
    logic       rw_q, rw_d;
    logic [6:0] dev_q, dev_d;
    logic [7:0] reg_q, reg_d;
    logic [3:0] rem_q, rem_d, rem_dec_c;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rdata_q, rdata_d;
    logic       err_q, err_d;
    logic       start_q, start_d;
    logic       cont_q, cont_d;
    logic       wd_ack_q, wd_ack_d;
    logic       rd_valid_q, rd_valid_d;
    logic       done_q, busy_q, ready_q;
    logic       live_c, to_fire_c;

    assign live_c    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign rem_dec_c = (rem_q != 4'd0) ? rem_q - 4'd1 : rem_q;

`ifdef IIC_CTRL_TIMEOUT_EN
    // Fire point chosen so done lands exactly TIMEOUT_CYC cycles after the last event cycle.
    localparam int unsigned TO_LAST = (TIMEOUT_CYC > 1) ? TIMEOUT_CYC - 2 : 0;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            ev_c;

    assign ev_c      = iic_w_done | iic_drdy | iic_trans_done | iic_trans_err;
    assign to_cnt_d  = (!busy_q || ev_c) ? '0 : to_cnt_q + TO_W'(1);
    assign to_fire_c = live_c && !ev_c && (to_cnt_q == TO_W'(TO_LAST));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) to_cnt_q <= '0;
        else       to_cnt_q <= to_cnt_d;
    end
`else
    assign to_fire_c = 1'b0;
`endif

    // Next-state and pulse generation; pulses land one cycle after the triggering event.
    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        dev_d      = dev_q;
        reg_d      = reg_q;
        rem_d      = rem_q;
        tx_d       = tx_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        start_d    = 1'b0;
        cont_d     = 1'b0;
        wd_ack_d   = 1'b0;
        rd_valid_d = 1'b0;

        case (state_q)
            S_IDLE: if (cmd_valid && ready_q) begin
                rw_d    = cmd_rw;
                dev_d   = cmd_dev;
                reg_d   = cmd_reg;
                rem_d   = (cmd_len == 4'd0) ? 4'd1 : cmd_len;
                err_d   = 1'b0;
                tx_d    = {cmd_dev, 1'b0};
                start_d = 1'b1;
                state_d = S_ADDR_W;
            end
            S_ADDR_W: if (iic_w_done) begin
                tx_d    = reg_q;
                cont_d  = 1'b1;
                state_d = S_REG;
            end
            S_REG: if (iic_w_done) begin
                if (rw_q) begin
                    tx_d    = {dev_q, 1'b1};
                    start_d = 1'b1;
                    state_d = S_ADDR_R;
                end else begin
                    tx_d    = wdata;
                    cont_d  = 1'b1;
                    state_d = S_WDATA;
                end
            end
            S_WDATA: if (iic_w_done) begin
                wd_ack_d = 1'b1;
                rem_d    = rem_dec_c;
                state_d  = (rem_q > 4'd1) ? S_WNEXT : S_WAIT_STOP;
            end
            // Next write byte is presented by the system in the wd_ack cycle.
            S_WNEXT: begin
                tx_d    = wdata;
                cont_d  = 1'b1;
                state_d = S_WDATA;
            end
            S_ADDR_R: if (iic_w_done) begin
                cont_d  = (rem_q > 4'd1);
                state_d = S_RDATA;
            end
            S_RDATA: if (iic_drdy) begin
                rdata_d    = iic_rx_data;
                rd_valid_d = 1'b1;
                rem_d      = rem_dec_c;
                if (rem_q > 4'd1) cont_d  = 1'b1;
                else              state_d = S_WAIT_STOP;
            end
            S_WAIT_STOP: if (iic_trans_done) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        // NACK, premature STOP or watchdog expiry abort the byte flow.
        if (live_c && (iic_trans_err || to_fire_c ||
                       (iic_trans_done && (state_q != S_WAIT_STOP)))) begin
            err_d      = 1'b1;
            start_d    = 1'b0;
            cont_d     = 1'b0;
            wd_ack_d   = 1'b0;
            rd_valid_d = 1'b0;
            state_d    = (iic_trans_done || to_fire_c) ? S_DONE : S_WAIT_STOP;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            rw_q       <= 1'b0;
            dev_q      <= 7'h00;
            reg_q      <= 8'h00;
            rem_q      <= 4'd0;
            tx_q       <= 8'h00;
            rdata_q    <= 8'h00;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
            cont_q     <= 1'b0;
            wd_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            dev_q      <= dev_d;
            reg_q      <= reg_d;
            rem_q      <= rem_d;
            tx_q       <= tx_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            start_q    <= start_d;
            cont_q     <= cont_d;
            wd_ack_q   <= wd_ack_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= (state_d == S_DONE);
            busy_q     <= (state_d != S_IDLE);
            ready_q    <= (state_d == S_IDLE);
        end
    end

    assign cmd_ready    = ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign wd_ack       = wd_ack_q;
    assign rd_valid     = rd_valid_q;
    assign rdata        = rdata_q;
    assign iic_start    = start_q;
    assign iic_continue = cont_q;
    assign iic_tx_data  = tx_q;

endmodule

// File: tb/tb_iic_reg_ctrl.sv
// Scoreboard bench for iic_reg_ctrl: stimulus pushes expected output events, a monitor pops and compares.

module tb_iic_reg_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_dev;
    logic [7:0] cmd_reg;
    logic [3:0] cmd_len;
    logic [7:0] wdata;
    logic       wd_ack, rd_valid, busy, done, err;
    logic [7:0] rdata;
    logic       iic_start, iic_continue;
    logic [7:0] iic_tx_data, iic_rx_data;
    logic       iic_w_done, iic_drdy, iic_trans_done, iic_trans_err;

    always #5 clk = ~clk;

`ifdef IIC_CTRL_TIMEOUT_EN
    iic_reg_ctrl #(.TO_W(18), .TIMEOUT_CYC(1000)) dut (
`else
    iic_reg_ctrl dut (
`endif
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_len(cmd_len),
        .wdata(wdata), .wd_ack(wd_ack), .rdata(rdata), .rd_valid(rd_valid),
        .busy(busy), .done(done), .err(err),
        .iic_start(iic_start), .iic_continue(iic_continue), .iic_tx_data(iic_tx_data),
        .iic_rx_data(iic_rx_data), .iic_w_done(iic_w_done), .iic_drdy(iic_drdy),
        .iic_trans_done(iic_trans_done), .iic_trans_err(iic_trans_err)
    );

    localparam logic [7:0] K_WDACK = 8'd1, K_RDV = 8'd2, K_START = 8'd3,
                           K_CONT  = 8'd4, K_DONE = 8'd5;

    typedef struct {
        logic [15:0] ev;
        int          at;
    } exp_t;

    exp_t       exp_q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    logic [7:0] wbytes [4];
    logic       wrst = 1'b0;
    int         widx = 0;

    function automatic string kname(input logic [7:0] k);
        case (k)
            K_WDACK: return "wd_ack";
            K_RDV:   return "rd_valid";
            K_START: return "iic_start";
            K_CONT:  return "iic_continue";
            K_DONE:  return "done";
            default: return "unknown";
        endcase
    endfunction

    function automatic void check(input string name, input int unsigned act, input int unsigned req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void expect_ev(input logic [7:0] k, input logic [7:0] d, input int at = -1);
        exp_t e;
        e.ev = {k, d};
        e.at = at;
        exp_q.push_back(e);
    endfunction

    function automatic void observe(input logic [7:0] k, input logic [7:0] d);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_%s: got data %0h, expected no output (cycle %0d)", kname(k), d, cyc);
        end else begin
            e = exp_q.pop_front();
            check({"ev_", kname(e.ev[15:8])}, 32'({k, d}), 32'(e.ev));
            if (e.at >= 0) check({"cycle_", kname(k)}, 32'(cyc), 32'(e.at));
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: one event per active output, fixed order within a cycle.
    initial forever begin
        @(negedge clk);
        if (rstn === 1'b1) begin
            if (wd_ack)       observe(K_WDACK, 8'h00);
            if (rd_valid)     observe(K_RDV, rdata);
            if (iic_start)    observe(K_START, iic_tx_data);
            if (iic_continue) observe(K_CONT, iic_tx_data);
            if (done)         observe(K_DONE, {7'b0, err});
        end
    end

    // System-side write-data source: advances on each wd_ack.
    initial forever begin
        @(negedge clk);
        if (wrst)                    widx = 0;
        else if (wd_ack && widx < 3) widx++;
        wdata = wbytes[widx];
    end

    task automatic load_w(input logic [7:0] b0, input logic [7:0] b1);
        @(posedge clk); #1;
        wbytes[0] = b0; wbytes[1] = b1; wbytes[2] = 8'hEE; wbytes[3] = 8'hEE;
        wrst = 1'b1;
        @(posedge clk); #1;
        wrst = 1'b0;
    endtask

    task automatic issue(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [3:0] len, output int acc);
        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_rw = rw; cmd_dev = dev; cmd_reg = rg; cmd_len = len;
        cmd_valid = 1'b1;
        acc = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic ev_pulse(input logic w, input logic d, input logic td, input logic te,
                            input logic [7:0] rx);
        @(negedge clk);
        iic_w_done = w; iic_drdy = d; iic_trans_done = td; iic_trans_err = te;
        iic_rx_data = rx;
        @(posedge clk); #1;
        iic_w_done = 1'b0; iic_drdy = 1'b0; iic_trans_done = 1'b0; iic_trans_err = 1'b0;
    endtask

    task automatic wait_out(input logic [7:0] k, input int limit);
        logic s;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            case (k)
                K_WDACK: s = wd_ack;
                K_RDV:   s = rd_valid;
                K_START: s = iic_start;
                K_CONT:  s = iic_continue;
                default: s = done;
            endcase
            if (s) return;
        end
        n_vec++;
        n_bad++;
        $display("FAIL wait_%s: got no pulse in %0d cycles, expected one", kname(k), limit);
    endtask

    task automatic drain(input string name);
        repeat (3) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, 32'({cmd_ready, busy, done, err, wd_ack, rd_valid, iic_start, iic_continue}),
              32'h80);
        check({tag, "_rdata"}, 32'(rdata), 32'h00);
        check({tag, "_tx"}, 32'(iic_tx_data), 32'h00);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected bench completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int acc;
        rstn = 1'b0;
        cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_dev = '0; cmd_reg = '0; cmd_len = '0;
        iic_rx_data = '0; iic_w_done = 1'b0; iic_drdy = 1'b0;
        iic_trans_done = 1'b0; iic_trans_err = 1'b0;
        for (int i = 0; i < 4; i++) wbytes[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        // Master events while idle must be ignored.
        ev_pulse(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
        repeat (2) @(negedge clk);
        check("idle_ignore", 32'({cmd_ready, busy, err}), 32'b100);
        drain("idle_queue");

        // 1: single-byte write, busy command ignored.
        load_w(8'hA5, 8'h00);
        expect_ev(K_START, 8'hA0); expect_ev(K_CONT, 8'h10); expect_ev(K_CONT, 8'hA5);
        expect_ev(K_WDACK, 8'h00); expect_ev(K_DONE, 8'h00);
        issue(1'b0, 7'h50, 8'h10, 4'd1, acc);
        wait_out(K_START, 50);
        @(negedge clk);
        check("cmd_ready_busy", 32'({cmd_ready, busy}), 32'b01);
        cmd_valid = 1'b1; cmd_dev = 7'h7F;
        @(posedge clk); #1 cmd_valid = 1'b0;
        ev_pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); wait_out(K_CONT, 50);
        ev_pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); wait_out(K_CONT, 50);
        ev_pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); wait_out(K_WDACK, 50);
        repeat (2) @(negedge clk);
        ev_pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'h00); wait_out(K_DONE, 50);
        drain("t1_queue");

        // 2: three-byte read with restart; stray w_done alongside a drdy.
        expect_ev(K_START, 8'hA0); expect_ev(K_CONT, 8'h02); expect_ev(K_START, 8'hA1);
        expect_ev(K_CONT, 8'hA1);
        expect_ev(K_RDV, 8'h11); expect_ev(K_CONT, 8'hA1);
        expect_ev(K_RDV, 8'h22); expect_ev(K_CONT, 8'hA1);
        expect_ev(K_RDV, 8'h33); expect_ev(K_DONE, 8'h00);
        issue(1'b1, 7'h50, 8'h02, 4'd3, acc);
        wait_out(K_START, 50);
        ev_pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); wait_out(K_CONT, 50);
        ev_pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); wait_out(K_START, 50);
        ev_pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); wait_out(K_CONT, 50);
        ev_pulse(1'b0, 1'b1, 1'b0, 1'b0, 8'h11); wait_out(K_RDV, 50);
        ev_pulse(1'b1, 1'b1, 1'b0, 1'b0, 8'h22); wait_out(K_RDV, 50);
        ev_pulse(1'b0, 1'b1, 1'b0, 1'b0, 8'h33); wait_out(K_RDV, 50);
        ev_pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'h00); wait_out(K_DONE, 50);
        drain("t2_queue");

        // 3: address NACK; err held after done.
        load_w(8'h77, 8'h88);
        expect_ev(K_START, 8'hA0); expect_ev(K_DONE, 8'h01);
        issue(1'b0, 7'h50, 8'h10, 4'd2, acc);
        wait_out(K_START, 50);
        ev_pulse(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        repeat (4) @(negedge clk);
        ev_pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'h00); wait_out(K_DONE, 50);
        drain("t3_queue");
        check("t3_err_held", 32'(err), 32'd1);

        // 4: len 0 behaves as one byte; err cleared on accept.
        load_w(8'h3C, 8'h00);
        expect_ev(K_START, 8'h22); expect_ev(K_CONT, 8'h5A); expect_ev(K_CONT, 8'h3C);
        expect_ev(K_WDACK, 8'h00); expect_ev(K_DONE, 8'h00);
        issue(1'b0, 7'h11, 8'h5A, 4'd0, acc);
        wait_out(K_START, 50);
        check("t4_err_cleared", 32'(err), 32'd0);
        ev_pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); wait_out(K_CONT, 50);
        ev_pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); wait_out(K_CONT, 50);
        ev_pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); wait_out(K_WDACK, 50);
        ev_pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'h00); wait_out(K_DONE, 50);
        drain("t4_queue");

        // 5: reset in the middle of a four-byte read, then a two-byte write.
        expect_ev(K_START, 8'hA0); expect_ev(K_CONT, 8'h40); expect_ev(K_START, 8'hA1);
        expect_ev(K_CONT, 8'hA1); expect_ev(K_RDV, 8'h5A); expect_ev(K_CONT, 8'hA1);
        issue(1'b1, 7'h50, 8'h40, 4'd4, acc);
        wait_out(K_START, 50);
        ev_pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); wait_out(K_CONT, 50);
        ev_pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); wait_out(K_START, 50);
        ev_pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); wait_out(K_CONT, 50);
        ev_pulse(1'b0, 1'b1, 1'b0, 1'b0, 8'h5A); wait_out(K_RDV, 50);
        check("t5_pre_reset_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #2 rstn = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("t5_reset");
        @(posedge clk); #1 rstn = 1'b1;
        load_w(8'hC1, 8'hC2);
        expect_ev(K_START, 8'h46); expect_ev(K_CONT, 8'h7E); expect_ev(K_CONT, 8'hC1);
        expect_ev(K_WDACK, 8'h00); expect_ev(K_CONT, 8'hC2); expect_ev(K_WDACK, 8'h00);
        expect_ev(K_DONE, 8'h00);
        issue(1'b0, 7'h23, 8'h7E, 4'd2, acc);
        wait_out(K_START, 50);
        ev_pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); wait_out(K_CONT, 50);
        ev_pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); wait_out(K_CONT, 50);
        ev_pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); wait_out(K_CONT, 50);
        ev_pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); wait_out(K_WDACK, 50);
        ev_pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'h00); wait_out(K_DONE, 50);
        drain("t5_queue");

        // 6: premature STOP while waiting on the register byte.
        expect_ev(K_START, 8'hA0); expect_ev(K_CONT, 8'h10); expect_ev(K_DONE, 8'h01);
        issue(1'b0, 7'h50, 8'h10, 4'd1, acc);
        wait_out(K_START, 50);
        ev_pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); wait_out(K_CONT, 50);
        ev_pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'h00); wait_out(K_DONE, 50);
        drain("t6_queue");

        // 7: NACK and STOP together with drdy in a read burst: straight to done, no rd_valid.
        expect_ev(K_START, 8'hA0); expect_ev(K_CONT, 8'h02); expect_ev(K_START, 8'hA1);
        expect_ev(K_CONT, 8'hA1); expect_ev(K_DONE, 8'h01);
        issue(1'b1, 7'h50, 8'h02, 4'd2, acc);
        wait_out(K_START, 50);
        ev_pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); wait_out(K_CONT, 50);
        ev_pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); wait_out(K_START, 50);
        ev_pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); wait_out(K_CONT, 50);
        ev_pulse(1'b0, 1'b1, 1'b1, 1'b1, 8'h99); wait_out(K_DONE, 50);
        drain("t7_queue");

`ifdef IIC_CTRL_TIMEOUT_EN
        // 8: master stalls after start; watchdog completes the command.
        issue(1'b0, 7'h50, 8'h10, 4'd1, acc);
        expect_ev(K_START, 8'hA0, acc + 1);
        expect_ev(K_DONE, 8'h01, acc + 1000);
        wait_out(K_DONE, 1100);
        @(negedge clk);
        check("t8_ready_after_timeout", 32'(cmd_ready), 32'd1);
        drain("t8_queue");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
